// File: rtl/hfrv_trace_pkg.sv
// ---------------------------------------------------------------------------
// hfrv_trace_pkg
// Shared types for the HF-RISC execution trace buffer.
//   state_e       : capture state machine encoding (IDLE/ARMED/POST/DONE)
//   mode_e        : latched capture mode (off / free-run / trigger-stop)
//   trace_entry_t : one trace record at the default core widths
//   OVF_W         : width of the saturating dropped-entry counter
//   decode_mode() : maps the raw 2-bit cfg_mode onto mode_e
// ---------------------------------------------------------------------------
package hfrv_trace_pkg;

    localparam int TRACE_XLEN = 32;
    localparam int TRACE_TS_W = 16;
    localparam int OVF_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_FREE = 2'b01,
        MODE_TRIG = 2'b10
    } mode_e;

    // Field order defines the rd_data bit layout: pc occupies the LSBs.
    typedef struct packed {
        logic [TRACE_TS_W-1:0] ts_delta;
        logic                  wb_we;
        logic [4:0]            wb_rd;
        logic [TRACE_XLEN-1:0] wb_data;
        logic [31:0]           instr;
        logic [TRACE_XLEN-1:0] pc;
    } trace_entry_t;

    // The reserved encoding 2'b11 behaves exactly like off.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_FREE;
            2'b10:   return MODE_TRIG;
            default: return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hfrv_trace_ram.sv
// ---------------------------------------------------------------------------
// hfrv_trace_ram
// Simple dual-port storage for trace entries.
//   clk   : write clock
//   we    : write enable, data stored at the rising edge
//   waddr : write address
//   wdata : entry to store
//   raddr : read address
//   rdata : entry at raddr (asynchronous read, gives show-ahead data)
// ---------------------------------------------------------------------------
module hfrv_trace_ram #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hfrv_trace_buffer.sv
// ---------------------------------------------------------------------------
// hfrv_trace_buffer
// Execution trace capture for the HF-RISC core: one entry per retired
// instruction, stored in a circular buffer and drained via valid/ready.
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   ret_*            : retire stream from the core
//   cfg_mode         : 00 off, 01 free-run, 10 trigger-stop, 11 off
//   cfg_trig_pc      : trigger PC for trigger-stop mode
//   cfg_post_cnt     : entries captured after the trigger entry
//   arm              : pulse - flush, latch cfg_*, start capture
//   rd_valid/ready   : read handshake, rd_data is show-ahead
//   rd_data          : {ts_delta, rd_we, rd, rd_data, instr, pc}
//   rd_last          : rd_data is the final buffered entry
//   state            : IDLE/ARMED/POST/DONE
//   count            : entries held (0..DEPTH)
//   overflow_cnt     : free-run entries dropped, saturating
// ---------------------------------------------------------------------------
module hfrv_trace_buffer
    import hfrv_trace_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int DEPTH   = 64,
    parameter  int TS_W    = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int ENTRY_W = TS_W + 1 + 5 + 2 * XLEN + 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_pc,
    input  logic [31:0]        ret_instr,
    input  logic               ret_rd_we,
    input  logic [4:0]         ret_rd,
    input  logic [XLEN-1:0]    ret_rd_data,
    input  logic [1:0]         cfg_mode,
    input  logic [XLEN-1:0]    cfg_trig_pc,
    input  logic [AW-1:0]      cfg_post_cnt,
    input  logic               arm,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_last,
    output logic [1:0]         state,
    output logic [AW:0]        count,
    output logic [OVF_W-1:0]   overflow_cnt
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("hfrv_trace_buffer: DEPTH must be a power of two >= 4");
    end

    // Entry layout at this instance's widths; same field order as the
    // package trace_entry_t.
    typedef struct packed {
        logic [TS_W-1:0] ts_delta;
        logic            wb_we;
        logic [4:0]      wb_rd;
        logic [XLEN-1:0] wb_data;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]      CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
    localparam logic [TS_W-1:0]  TS_MAX   = '1;
    localparam logic [OVF_W-1:0] OVF_ONE  = OVF_W'(1);
    localparam logic [OVF_W-1:0] OVF_MAX  = '1;

    state_e            state_reg, state_next;
    mode_e             mode_reg, mode_next;
    logic [XLEN-1:0]   trig_pc_reg, trig_pc_next;
    logic [AW-1:0]     post_cnt_reg, post_cnt_next;
    logic [AW-1:0]     post_left_reg, post_left_next;
    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [AW:0]       count_reg, count_next;
    logic [OVF_W-1:0]  ovf_reg, ovf_next;
    logic [TS_W-1:0]   ts_reg, ts_next;

    logic              full;
    logic              rd_valid_int;
    logic              pop;
    logic              ram_we;
    logic              trig_wr;
    logic [TS_W-1:0]   ts_sat;
    entry_t            wr_entry;
    logic [ENTRY_W-1:0] ram_rdata;

    assign full = (count_reg == CNT_FULL);

    // Entries are only visible in free-run (live FIFO) or after a trigger
    // window has completed; during trigger capture the buffer is hidden.
    assign rd_valid_int = (count_reg != '0) &&
                          (((state_reg == ARMED) && (mode_reg == MODE_FREE)) ||
                           (state_reg == DONE));
    assign pop = rd_valid_int && rd_ready;

    // ts_reg holds cycles elapsed minus one since the last capture/arm, so
    // the delta recorded for a retire is ts_reg + 1, saturated.
    assign ts_sat = (ts_reg == TS_MAX) ? TS_MAX : ts_reg + TS_ONE;

    always_comb begin
        wr_entry          = '0;
        wr_entry.ts_delta = ts_sat;
        wr_entry.wb_we    = ret_rd_we;
        wr_entry.wb_rd    = ret_rd;
        wr_entry.wb_data  = ret_rd_data;
        wr_entry.instr    = ret_instr;
        wr_entry.pc       = ret_pc;
    end

    hfrv_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    // Next-state and datapath logic.
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        trig_pc_next   = trig_pc_reg;
        post_cnt_next  = post_cnt_reg;
        post_left_next = post_left_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        ovf_next       = ovf_reg;
        ts_next        = ts_sat;
        ram_we         = 1'b0;
        trig_wr        = 1'b0;

        if (arm) begin
            // arm overrides any same-cycle retire or pop.
            mode_next      = decode_mode(cfg_mode);
            trig_pc_next   = cfg_trig_pc;
            post_cnt_next  = cfg_post_cnt;
            post_left_next = '0;
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            ovf_next       = '0;
            ts_next        = '0;
            state_next     = (decode_mode(cfg_mode) == MODE_OFF) ? IDLE : ARMED;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (mode_reg == MODE_FREE) begin
                        if (ret_valid) begin
                            if (full && !pop) begin
                                ovf_next = (ovf_reg == OVF_MAX) ? OVF_MAX : ovf_reg + OVF_ONE;
                            end else begin
                                ram_we      = 1'b1;
                                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                                ts_next     = '0;
                            end
                        end
                        if (pop) begin
                            rd_ptr_next = rd_ptr_reg + PTR_ONE;
                        end
                        if (ram_we && !pop) begin
                            count_next = count_reg + CNT_ONE;
                        end else if (!ram_we && pop) begin
                            count_next = count_reg - CNT_ONE;
                        end
                    end else if (ret_valid) begin
                        trig_wr = 1'b1;
                        if (ret_pc == trig_pc_reg) begin
                            post_left_next = post_cnt_reg;
                            state_next     = (post_cnt_reg == '0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (ret_valid) begin
                        trig_wr        = 1'b1;
                        post_left_next = post_left_reg - PTR_ONE;
                        if (post_left_reg == PTR_ONE) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr_next = rd_ptr_reg + PTR_ONE;
                        count_next  = count_reg - CNT_ONE;
                        if (count_reg == CNT_ONE) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: ;
            endcase

            // Trigger-stop capture is a circular overwrite: when full, the
            // read pointer follows the write pointer to discard the oldest.
            if (trig_wr) begin
                ram_we      = 1'b1;
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                ts_next     = '0;
                if (full) begin
                    rd_ptr_next = rd_ptr_reg + PTR_ONE;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg      <= MODE_OFF;
            trig_pc_reg   <= '0;
            post_cnt_reg  <= '0;
            post_left_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            ovf_reg       <= '0;
            ts_reg        <= '0;
        end else begin
            mode_reg      <= mode_next;
            trig_pc_reg   <= trig_pc_next;
            post_cnt_reg  <= post_cnt_next;
            post_left_reg <= post_left_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            ovf_reg       <= ovf_next;
            ts_reg        <= ts_next;
        end
    end

    assign rd_valid     = rd_valid_int;
    assign rd_data      = rd_valid_int ? ram_rdata : '0;
    assign rd_last      = rd_valid_int && (count_reg == CNT_ONE);
    assign state        = state_reg;
    assign count        = count_reg;
    assign overflow_cnt = ovf_reg;

endmodule

// File: doc/hfrv_trace_buffer.md
Name: hfrv_trace_buffer

Overview:
Synthesisable on-chip execution trace capture for the HF-RISC core. It records one entry per retired instruction: PC, instruction word, register writeback and a cycle-delta timestamp. Entries go into a parametrised circular buffer with free-run and PC-triggered modes, and drain through a valid/ready read port. The block sits beside dut_top, fed from the core's retire signals. It gives silicon and emulation builds the instruction/register history the software monitors produce in simulation.

Parameters:
XLEN, 32, data/PC width
DEPTH, 64, entries in buffer; power of two, >= 4
TS_W, 16, timestamp delta width
AW, $clog2(DEPTH), derived pointer width (localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ret_valid  in  1  one instruction retired this cycle
ret_pc  in  XLEN  PC of retired instruction
ret_instr  in  32  instruction word
ret_rd_we  in  1  register writeback occurred
ret_rd  in  5  destination register
ret_rd_data  in  XLEN  writeback value
cfg_mode  in  2  00 off, 01 free-run, 10 trigger-stop, 11 reserved (treated as off)
cfg_trig_pc  in  XLEN  trigger PC (trigger-stop mode)
cfg_post_cnt  in  AW  entries captured after the trigger entry
arm  in  1  single-cycle pulse: clear buffer, sample cfg, start capture
rd_valid  out  1  rd_data holds an entry
rd_ready  in  1  consumer accepts entry
rd_data  out  TS_W+1+5+2*XLEN+32  {ts_delta, rd_we, rd, rd_data, instr, pc}
rd_last  out  1  rd_data is the final buffered entry
state  out  2  IDLE/ARMED/POST/DONE
count  out  AW+1  entries held
overflow_cnt  out  16  entries dropped in free-run, saturating

Behaviour:
- Reset (async, rst_n low): state=IDLE; pointers, count, overflow_cnt, timestamp counter cleared; rd_valid=0, rd_last=0, rd_data=0.
- arm (any state): flush buffer, clear overflow_cnt and ts counter, latch mode/trig_pc/post_cnt. mode 00/11 -> IDLE, else -> ARMED. Unlatched cfg changes have no effect.
- Capture: ret_valid in cycle N writes an entry at edge N+1. count/rd_valid reflect it from N+1. No capture in IDLE or DONE. arm and ret_valid in the same cycle: arm wins, entry discarded.
- ts_delta: cycles since the previous captured entry, or since arm for the first entry. Saturates at 2^TS_W-1. The counter resets to 0 on each capture.
- Free-run (ARMED, mode 01):
  - Buffer acts as a FIFO; reads are allowed concurrently.
  - Full with no simultaneous pop: new entry dropped, overflow_cnt+1 (saturating at 0xFFFF).
  - Full with simultaneous pop: write accepted, count unchanged.
  - Never leaves ARMED except on arm or reset.
- Trigger-stop (mode 10):
  - ARMED: circular overwrite; when full, the oldest entry is discarded; overflow_cnt unchanged. rd_valid=0.
  - Trigger when ret_valid && ret_pc==trig_pc. The trigger entry is captured. post_cnt==0 -> DONE next edge; else -> POST.
  - POST: capture post_cnt further entries, overwriting the oldest. The edge writing the last one -> DONE.
  - DONE: capture frozen. rd_valid=1 while count>0, oldest first. When the last entry pops -> IDLE.
- Read port: rd_data is show-ahead from the read pointer. rd_data/rd_valid are stable while rd_valid && !rd_ready. A pop occurs when rd_valid && rd_ready. rd_last = rd_valid && count==1. rd_ready with rd_valid=0 is ignored.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Decomposition:
- Package hfrv_trace_pkg:
  - state_e (IDLE, ARMED, POST, DONE)
  - mode_e (OFF, FREE, TRIG)
  - trace_entry_t packed struct, parametrised via XLEN/TS_W localparams
  - OVF_W=16
- Sub-module hfrv_trace_ram: simple dual-port DEPTH x entry-width memory. Synchronous write, asynchronous read.
- FSM, pointers, timestamp and trigger compare stay in the top.

Test Plan:
- Reset mid-capture: free-run, 10 retires, rst_n low 1 cycle -> state=IDLE, count=0, rd_valid=0, overflow_cnt=0 immediately.
- Free-run drain: arm mode 01, 5 retires PC 0x100..0x110 step 4, rd_ready=1 -> 5 pops in PC order; ts_delta of first = cycles since arm; rd_last on 5th.
- Free-run overflow: DEPTH=64, rd_ready=0, 70 retires -> count=64, overflow_cnt=6, first read PC = first captured.
- Trigger window: mode 10, trig_pc=0x200, post_cnt=3, 100 sequential retires ending past 0x200 -> DONE; 64 entries, last four = 0x200..0x20C; after 64 pops state=IDLE.
- Trigger with post_cnt=0 on the first retire -> DONE next edge, count=1, rd_last=1.
- Timestamp saturation: TS_W=4, 20-cycle gap between retires -> ts_delta=15; back-to-back retires -> ts_delta=1.
